mcac_dec_sin: RTL and testbench

Serial ADPCM code receiver sitting directly upstream of the MCAC decoder (dec).
- Accepts the G.726 code bitstream: MSB first, one bit per strobe, with a per-word frame sync.
- Assembles each CODE_W-bit code word and buffers it in a small FIFO.
- Presents codes to the decoder core over a valid/ready handshake.
- Flags framing errors and FIFO overflow.

---
 rtl/mcac_dec_sin_if.sv | 21 ++
 rtl/mcac_dec_sin.sv | 143 ++++++++++++++
 tb/tb_mcac_dec_sin.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcac_dec_sin_if.sv
// Code word handshake between the serial receiver and the MCAC decoder core.
// The master presents the FIFO head; the slave accepts it with code_ready.
interface mcac_dec_sin_if #(
  parameter int CODE_W = 4
);
  logic [CODE_W-1:0] code;
  logic              code_valid;
  logic              code_ready;

  modport master (
    output code,
    output code_valid,
    input  code_ready
  );

  modport slave (
    input  code,
    input  code_valid,
    output code_ready
  );
endinterface

// File: rtl/mcac_dec_sin.sv
// Serial ADPCM code receiver: frame-synced MSB-first assembler feeding a
// small registered FIFO that hands codes to the decoder core.
module mcac_dec_sin #(
  parameter int CODE_W     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scan_in0,
  input  logic             scan_en,
  output logic             scan_out0,
  input  logic             sdata,
  input  logic             sdata_en,
  input  logic             fsync,
  mcac_dec_sin_if.master   dec,
  output logic             frame_err,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic [LVL_W-1:0] level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CODE_W + 1);

  typedef enum logic {
    HUNT,
    ASSEMBLE
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [CODE_W-1:0] sh_q;
  logic              frame_err_q;

  logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q;
  logic [AW-1:0]     rd_q;
  logic [LVL_W-1:0]  level_q;
  logic              ovf_q;

  logic [CODE_W-1:0] word_w;
  logic [CODE_W-1:0] first_w;
  logic              push_w;
  logic              pop_w;
  logic              full_w;
  logic              wr_en_w;
  logic              drop_w;
  logic              unused_scan;

  assign unused_scan = scan_in0 ^ scan_en;
  assign scan_out0   = 1'b0;

  assign word_w  = {sh_q[CODE_W-2:0], sdata};
  assign first_w = {{(CODE_W-1){1'b0}}, sdata};

  // The closing bit is written straight into the FIFO on its own edge.
  assign push_w = sdata_en && !fsync
               && (state_q == ASSEMBLE)
               && (cnt_q == CW'(CODE_W - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= HUNT;
      cnt_q       <= '0;
      sh_q        <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (sdata_en) begin
        unique case (state_q)
          HUNT: begin
            if (fsync) begin
              sh_q    <= first_w;
              cnt_q   <= CW'(1);
              state_q <= ASSEMBLE;
            end
          end
          ASSEMBLE: begin
            if (fsync) begin
              frame_err_q <= 1'b1;
              sh_q        <= first_w;
              cnt_q       <= CW'(1);
            end else if (push_w) begin
              sh_q    <= '0;
              cnt_q   <= '0;
              state_q <= HUNT;
            end else begin
              sh_q  <= word_w;
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign pop_w   = dec.code_valid && dec.code_ready;
  assign full_w  = (level_q == LVL_W'(FIFO_DEPTH));
  assign wr_en_w = push_w && (!full_w || pop_w);
  assign drop_w  = push_w && full_w && !pop_w;

  always_ff @(posedge clk) begin
    if (wr_en_w) begin
      mem_q[wr_q] <= word_w;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (wr_en_w) begin
        wr_q <= wr_q + AW'(1);
      end
      if (pop_w) begin
        rd_q <= rd_q + AW'(1);
      end
      unique case (1'b1)
        wr_en_w && !pop_w: level_q <= level_q + LVL_W'(1);
        pop_w && !wr_en_w: level_q <= level_q - LVL_W'(1);
        default:           level_q <= level_q;
      endcase
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop_w) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign dec.code_valid = (level_q != '0);
  assign dec.code       = (level_q != '0) ? mem_q[rd_q] : '0;
  assign frame_err      = frame_err_q;
  assign ovf            = ovf_q;
  assign level          = level_q;

endmodule

// File: tb/tb_mcac_dec_sin.sv
// Directed bench for mcac_dec_sin with an expected-code scoreboard.
// Widths 4, 2 and 5 share the serial stimulus; each has its own handshake.
module tb_mcac_dec_sin;

  logic clk;
  logic rst_n;
  logic sd;
  logic sen;
  logic fsy;
  logic oclr;

  logic       so4, fe4, ovf4;
  logic       so2, fe2, ovf2;
  logic       so5, fe5, ovf5;
  logic [2:0] lvl4, lvl2, lvl5;

  int errors = 0;
  int checks = 0;
  logic [31:0] exq[$];

  mcac_dec_sin_if #(.CODE_W(4)) if4 ();
  mcac_dec_sin_if #(.CODE_W(2)) if2 ();
  mcac_dec_sin_if #(.CODE_W(5)) if5 ();

  mcac_dec_sin #(.CODE_W(4), .FIFO_DEPTH(4), .LVL_W(3)) u4 (
    .clk(clk), .reset(rst_n), .scan_in0(1'b0), .scan_en(1'b0),
    .scan_out0(so4), .sdata(sd), .sdata_en(sen), .fsync(fsy),
    .dec(if4.master), .frame_err(fe4), .ovf(ovf4),
    .ovf_clr(oclr), .level(lvl4)
  );

  mcac_dec_sin #(.CODE_W(2), .FIFO_DEPTH(4), .LVL_W(3)) u2 (
    .clk(clk), .reset(rst_n), .scan_in0(1'b0), .scan_en(1'b0),
    .scan_out0(so2), .sdata(sd), .sdata_en(sen), .fsync(fsy),
    .dec(if2.master), .frame_err(fe2), .ovf(ovf2),
    .ovf_clr(oclr), .level(lvl2)
  );

  mcac_dec_sin #(.CODE_W(5), .FIFO_DEPTH(4), .LVL_W(3)) u5 (
    .clk(clk), .reset(rst_n), .scan_in0(1'b0), .scan_en(1'b0),
    .scan_out0(so5), .sdata(sd), .sdata_en(sen), .fsync(fsy),
    .dec(if5.master), .frame_err(fe5), .ovf(ovf5),
    .ovf_clr(oclr), .level(lvl5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag, input logic [31:0] obs);
    if (exq.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s obs=%0h exp=none", tag, obs);
    end else begin
      chk(tag, obs, exq.pop_front());
    end
  endtask

  task automatic strobe(input logic d, input logic fs, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    sd  = d;
    sen = 1'b1;
    fsy = fs;
    @(negedge clk);
    sd  = 1'b0;
    sen = 1'b0;
    fsy = 1'b0;
  endtask

  task automatic send_word(input logic [4:0] w, input int wd,
                           input int gap);
    for (int i = wd - 1; i >= 0; i--) begin
      strobe(w[i], i == wd - 1, gap);
    end
  endtask

  task automatic drain(input int n, input string tag);
    int t;
    for (int i = 0; i < n; i++) begin
      if4.code_ready = 1'b1;
      t = 0;
      while (!if4.code_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!if4.code_valid) begin
        checks++;
        errors++;
        $error("FAIL %s obs=novalid exp=valid", tag);
      end else begin
        chk_pop(tag, 32'(if4.code));
      end
      @(negedge clk);
    end
    if4.code_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    sd = 1'b0;
    sen = 1'b0;
    fsy = 1'b0;
    oclr = 1'b0;
    if4.code_ready = 1'b0;
    if2.code_ready = 1'b0;
    if5.code_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(if4.code_valid), 0);
    chk("rst_code", 32'(if4.code), 0);
    chk("rst_level", 32'(lvl4), 0);
    chk("rst_ovf", 32'(ovf4), 0);
    chk("rst_ferr", 32'(fe4), 0);
    chk("rst_scan", 32'({so4, so2, so5}), 0);
    chk("rst_w25", 32'({fe2, ovf2, fe5, ovf5}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: slow strobes, one word 4'hB
    exq.push_back(32'hB);
    send_word(5'hB, 4, 3);
    chk("t1_valid", 32'(if4.code_valid), 1);
    chk("t1_level", 32'(lvl4), 1);
    chk_pop("t1_code", 32'(if4.code));
    if4.code_ready = 1'b1;
    @(negedge clk);
    if4.code_ready = 1'b0;
    chk("t1_valid0", 32'(if4.code_valid), 0);
    chk("t1_level0", 32'(lvl4), 0);
    chk("t1_code0", 32'(if4.code), 0);

    // 2: truncated word then 4'h5
    strobe(1'b1, 1'b1, 0);
    strobe(1'b1, 1'b0, 0);
    strobe(1'b0, 1'b1, 0);
    chk("t2_ferr", 32'(fe4), 1);
    @(negedge clk);
    chk("t2_ferr_end", 32'(fe4), 0);
    strobe(1'b1, 1'b0, 0);
    strobe(1'b0, 1'b0, 0);
    strobe(1'b1, 1'b0, 0);
    chk("t2_level", 32'(lvl4), 1);
    chk("t2_ferr_q", 32'(fe4), 0);
    exq.push_back(32'h5);
    drain(1, "t2_code");
    chk("t2_empty", 32'(lvl4), 0);

    // 3: overflow with 5 words
    for (int w = 1; w <= 5; w++) begin
      send_word(5'(w), 4, 0);
      if (w <= 4) exq.push_back(32'(w));
      if (w == 4) chk("t3_ovf_pre", 32'(ovf4), 0);
    end
    chk("t3_level", 32'(lvl4), 4);
    chk("t3_ovf", 32'(ovf4), 1);
    drain(4, "t3_code");
    chk("t3_empty", 32'(lvl4), 0);
    chk("t3_ovf_hold", 32'(ovf4), 1);
    oclr = 1'b1;
    @(negedge clk);
    oclr = 1'b0;
    chk("t3_ovf_clr", 32'(ovf4), 0);

    // 4: full FIFO, last bit of word 6 with a pop
    for (int w = 1; w <= 4; w++) begin
      send_word(5'(w), 4, 0);
      exq.push_back(32'(w));
    end
    strobe(1'b0, 1'b1, 0);
    strobe(1'b1, 1'b0, 0);
    strobe(1'b1, 1'b0, 0);
    chk("t4_full", 32'(lvl4), 4);
    chk_pop("t4_head", 32'(if4.code));
    @(negedge clk);
    if4.code_ready = 1'b1;
    sd  = 1'b0;
    sen = 1'b1;
    @(negedge clk);
    sen = 1'b0;
    if4.code_ready = 1'b0;
    exq.push_back(32'h6);
    chk("t4_level", 32'(lvl4), 4);
    chk("t4_ovf", 32'(ovf4), 0);
    drain(4, "t4_code");

    // 5: hunt discards, fsync without strobe ignored
    @(negedge clk);
    sd  = 1'b1;
    fsy = 1'b1;
    @(negedge clk);
    sd  = 1'b0;
    fsy = 1'b0;
    strobe(1'b0, 1'b0, 0);
    strobe(1'b0, 1'b0, 0);
    strobe(1'b1, 1'b0, 0);
    chk("t5_discard", 32'(lvl4), 0);
    chk("t5_ferr", 32'(fe4), 0);
    exq.push_back(32'h9);
    send_word(5'h9, 4, 0);
    chk("t5_level", 32'(lvl4), 1);
    drain(1, "t5_code");

    // 6: reset mid-word with two entries queued
    send_word(5'hA, 4, 0);
    send_word(5'hC, 4, 0);
    strobe(1'b1, 1'b1, 0);
    strobe(1'b0, 1'b0, 0);
    chk("t6_pre", 32'(lvl4), 2);
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(if4.code_valid), 0);
    chk("t6_code", 32'(if4.code), 0);
    chk("t6_level", 32'(lvl4), 0);
    chk("t6_flags", 32'({fe4, ovf4, so4}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    strobe(1'b1, 1'b0, 0);
    strobe(1'b1, 1'b0, 0);
    chk("t6_nofsync", 32'(lvl4), 0);
    exq.push_back(32'h3);
    send_word(5'h3, 4, 0);
    chk("t6_level1", 32'(lvl4), 1);
    drain(1, "t6_code3");
    chk("t6_empty", 32'(lvl4), 0);

    // width 2: bits 1,0
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_word(5'b00010, 2, 3);
    chk("w2_valid", 32'(if2.code_valid), 1);
    chk("w2_code", 32'(if2.code), 32'h2);
    chk("w2_level", 32'(lvl2), 1);

    // width 5: 1,0,0,1,1
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_word(5'b10011, 5, 3);
    chk("w5_valid", 32'(if5.code_valid), 1);
    chk("w5_code", 32'(if5.code), 32'h13);
    chk("w5_level", 32'(lvl5), 1);
    if5.code_ready = 1'b1;
    @(negedge clk);
    if5.code_ready = 1'b0;
    chk("w5_pop", 32'(if5.code_valid), 0);
    chk("w5_left", 32'(exq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
